// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU/MTHI/MTLO, 32-iteration restoring DIV/DIVU.
// Optional write-through bypass of HI/LO outputs: define HILO_BYPASS_EN.
module hilo_muldiv #(
    parameter logic [4:0] MULT_OP  = 5'b00110,
    parameter logic [4:0] MULTU_OP = 5'b00111,
    parameter logic [4:0] DIV_OP   = 5'b01000,
    parameter logic [4:0] DIVU_OP  = 5'b01001,
    parameter logic [4:0] MTHI_OP  = 5'b10010,
    parameter logic [4:0] MTLO_OP  = 5'b10011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [4:0]  alu_ctrl_out,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        divideZero
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DIV_FIX = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic [5:0]  r_cnt;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_busy;
    logic        r_done;
    logic        r_dz;

    logic        w_op_valid;
    logic        w_is_div;
    logic        w_is_signed;
    logic        w_accept;
    logic        w_wr_hi;
    logic        w_wr_lo;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;
    logic [63:0] w_mul_s;
    logic [63:0] w_mul_u;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_trial;

    // Operation decode
    always_comb begin
        w_op_valid  = 1'b0;
        w_is_div    = 1'b0;
        w_is_signed = 1'b0;
        case (alu_ctrl_out)
            MULT_OP, MULTU_OP, MTHI_OP, MTLO_OP: w_op_valid = 1'b1;
            DIV_OP: begin
                w_op_valid  = 1'b1;
                w_is_div    = 1'b1;
                w_is_signed = 1'b1;
            end
            DIVU_OP: begin
                w_op_valid = 1'b1;
                w_is_div   = 1'b1;
            end
            default: w_op_valid = 1'b0;
        endcase
    end

    assign w_accept = start & ~flush & (r_state == S_IDLE) & w_op_valid;

    // Low 64 bits of the sign- or zero-extended product are the exact 64-bit result
    assign w_mul_s = {{32{op1[31]}}, op1} * {{32{op2[31]}}, op2};
    assign w_mul_u = {32'd0, op1} * {32'd0, op2};

    assign w_mag_a = (w_is_signed & op1[31]) ? (~op1 + 32'd1) : op1;
    assign w_mag_b = (w_is_signed & op2[31]) ? (~op2 + 32'd1) : op2;

    // Bit 32 set means the trial subtraction went negative
    assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_dvsr};

    // Single-cycle HI/LO write data
    always_comb begin
        w_wr_hi   = 1'b0;
        w_wr_lo   = 1'b0;
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (w_accept) begin
            case (alu_ctrl_out)
                MULT_OP: begin
                    w_wr_hi   = 1'b1;
                    w_wr_lo   = 1'b1;
                    w_hi_next = w_mul_s[63:32];
                    w_lo_next = w_mul_s[31:0];
                end
                MULTU_OP: begin
                    w_wr_hi   = 1'b1;
                    w_wr_lo   = 1'b1;
                    w_hi_next = w_mul_u[63:32];
                    w_lo_next = w_mul_u[31:0];
                end
                MTHI_OP: begin
                    w_wr_hi   = 1'b1;
                    w_hi_next = op1;
                end
                MTLO_OP: begin
                    w_wr_lo   = 1'b1;
                    w_lo_next = op1;
                end
                default: w_wr_hi = 1'b0;
            endcase
        end else begin
            w_wr_hi = 1'b0;
            w_wr_lo = 1'b0;
        end
    end

    // Control FSM, divider datapath and HI/LO registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvsr   <= 32'd0;
            r_cnt    <= 6'd0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_div) begin
                        if (op2 == 32'd0) begin
                            r_done <= 1'b1;
                            r_dz   <= 1'b1;
                        end else begin
                            r_quo    <= w_mag_a;
                            r_dvsr   <= w_mag_b;
                            r_sign_q <= w_is_signed & (op1[31] ^ op2[31]);
                            r_sign_r <= w_is_signed & op1[31];
                            r_rem    <= 32'd0;
                            r_cnt    <= 6'd0;
                            r_busy   <= 1'b1;
                            r_state  <= S_DIV_RUN;
                        end
                    end else if (w_accept) begin
                        if (w_wr_hi) r_hi <= w_hi_next;
                        if (w_wr_lo) r_lo <= w_lo_next;
                        r_done <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_trial[32] ? {r_rem[30:0], r_quo[31]} : w_trial[31:0];
                        r_quo <= {r_quo[30:0], ~w_trial[32]};
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) r_state <= S_DIV_FIX;
                        else                r_state <= S_DIV_RUN;
                    end
                end
                S_DIV_FIX: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_lo    <= r_sign_q ? (~r_quo + 32'd1) : r_quo;
                        r_hi    <= r_sign_r ? (~r_rem + 32'd1) : r_rem;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi_out = w_wr_hi ? w_hi_next : r_hi;
    assign lo_out = w_wr_lo ? w_lo_next : r_lo;
`else
    assign hi_out = r_hi;
    assign lo_out = r_lo;
`endif
    assign busy       = r_busy;
    assign done       = r_done;
    assign divideZero = r_dz;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized scoreboard bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

    localparam logic [4:0] C_MULT  = 5'b00110;
    localparam logic [4:0] C_MULTU = 5'b00111;
    localparam logic [4:0] C_DIV   = 5'b01000;
    localparam logic [4:0] C_DIVU  = 5'b01001;
    localparam logic [4:0] C_MTHI  = 5'b10010;
    localparam logic [4:0] C_MTLO  = 5'b10011;
    localparam logic [4:0] C_BAD   = 5'b11111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  alu_ctrl_out = 5'd0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        divideZero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        prev_done = 1'b0;

    hilo_muldiv dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .alu_ctrl_out(alu_ctrl_out), .op1(op1), .op2(op2),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
        .divideZero(divideZero)
    );

    always #5 clock = ~clock;

    // Monitor: every done pulse retires the oldest expected result
    always @(negedge clock) begin
        if (!reset) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                exp_t e;
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high on two consecutive cycles");
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h dz=%b, no result expected", hi_out, lo_out, divideZero);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (hi_out !== e.hi || lo_out !== e.lo || divideZero !== e.dz) begin
                        errors++;
                        $display("FAIL result: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                                 hi_out, lo_out, divideZero, e.hi, e.lo, e.dz);
                    end
                end
            end else if (divideZero) begin
                errors++;
                $display("FAIL dz_without_done: divideZero=1 while done=0");
            end
            prev_done = done;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model plus drive; expected results are queued before the accept edge
    task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sbv;
        bit          is_div;
        bit          valid;
        int          n;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        is_div = (code == C_DIV) || (code == C_DIVU);
        valid = 1'b1;
        e.dz = 1'b0;
        if (code == C_MULT) begin
            p = sa * sbv;
            m_hi = p[63:32]; m_lo = p[31:0];
        end else if (code == C_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0];
        end else if (code == C_MTHI) begin
            m_hi = a;
        end else if (code == C_MTLO) begin
            m_lo = a;
        end else if (is_div && b == 32'd0) begin
            e.dz = 1'b1;
        end else if (code == C_DIV) begin
            p = sa / sbv; m_lo = p[31:0];
            p = sa % sbv; m_hi = p[31:0];
        end else if (code == C_DIVU) begin
            m_lo = a / b; m_hi = a % b;
        end else begin
            valid = 1'b0;
        end
        e.hi = m_hi; e.lo = m_lo;
        if (valid) sb.push_back(e);

        @(negedge clock);
        start = 1'b1; alu_ctrl_out = code; op1 = a; op2 = b;
        @(negedge clock);
        start = 1'b0;
        if (is_div && b != 32'd0) begin
            n = 0;
            while (busy === 1'b1 && n < 100) begin
                n++;
                if (n == 5) begin
                    start = 1'b1; alu_ctrl_out = C_MULT;
                    op1 = $urandom; op2 = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(negedge clock);
            end
            start = 1'b0;
            check32("div_busy_cycles", n, 32'd33);
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_single: busy=%b expected 0", busy);
            end
        end
        @(negedge clock);
        check32("hi_steady", hi_out, m_hi);
        check32("lo_steady", lo_out, m_lo);
    endtask

    task automatic div_with_flush(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clock);
        start = 1'b1; alu_ctrl_out = C_DIV; op1 = a; op2 = b;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            n++;
            if (n == 10) begin
                flush = 1'b1;
                start = 1'b1; alu_ctrl_out = C_MTHI; op1 = 32'hDEADBEEF;
            end
            @(negedge clock);
        end
        flush = 1'b0; start = 1'b0;
        check32("flush_busy_seen", n, 32'd10);
        check32("flush_busy_drop", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clock);
        check32("flush_hi", hi_out, m_hi);
        check32("flush_lo", lo_out, m_lo);
    endtask

    initial begin
        logic [4:0] codes [7];
        codes = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_MTHI, C_MTLO, C_BAD};

        #2;
        check32("reset_hi", hi_out, 32'd0);
        check32("reset_lo", lo_out, 32'd0);
        check32("reset_flags", {29'd0, busy, done, divideZero}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        issue(C_MULT,  32'hFFFFFFFE, 32'd3);
        issue(C_MULTU, 32'hFFFFFFFE, 32'd3);
        issue(C_MTHI,  32'h12345678, 32'd0);
        issue(C_DIV,   32'hFFFFFFF9, 32'd2);
        issue(C_DIVU,  32'd100,      32'd0);
        issue(C_DIV,   32'h80000000, 32'hFFFFFFFF);
        issue(C_DIVU,  32'hFFFFFFFF, 32'd16);
        issue(C_MTLO,  32'hCAFEF00D, 32'd5);
        issue(C_BAD,   32'h11111111, 32'h22222222);
        div_with_flush(32'd100, 32'd7);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 300);
            issue(codes[$urandom_range(0, 6)], a, b);
        end

        // Asynchronous reset in the middle of a divide
        @(negedge clock);
        start = 1'b1; alu_ctrl_out = C_DIVU; op1 = 32'd1000; op2 = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check32("async_reset_hi", hi_out, 32'd0);
        check32("async_reset_lo", lo_out, 32'd0);
        check32("async_reset_flags", {29'd0, busy, done, divideZero}, 32'd0);
        sb.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clock);
        reset = 1'b1;
        issue(C_MULT, 32'h00010000, 32'h00010000);

        repeat (5) @(negedge clock);
        check32("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage companion to the ALU.
- Receives the same alu_ctrl_out, op1 and op2 as the ALU, and owns the architectural HI/LO registers.
- MULT/MULTU and MTHI/MTLO complete in one cycle.
- DIV/DIVU run a 32-iteration restoring divider, with a busy handshake that stalls the pipeline.
- hi_out/lo_out feed the MFHI/MFLO path.

Parameters:
- MULT_OP, default 5'b00110: signed multiply code.
- MULTU_OP, default 5'b00111: unsigned multiply code.
- DIV_OP, default 5'b01000: signed divide code.
- DIVU_OP, default 5'b01001: unsigned divide code.
- MTHI_OP, default 5'b10010: move op1 to HI.
- MTLO_OP, default 5'b10011: move op1 to LO.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset=0 asserts)
- start  input  1  EX-stage instruction valid for this unit
- flush  input  1  cancel any in-progress divide
- alu_ctrl_out  input  5  operation code
- op1  input  32  rs operand / dividend
- op2  input  32  rt operand / divisor
- hi_out  output  32  HI register
- lo_out  output  32  LO register
- busy  output  1  divide in progress; upstream holds EX while high
- done  output  1  one-cycle pulse: operation retired
- divideZero  output  1  one-cycle pulse: divide by zero

Behaviour:
- Reset (async, reset=0): hi_out=0, lo_out=0, busy=0, done=0, divideZero=0, state=IDLE, all datapath registers cleared. Takes effect immediately, including mid-divide.
- States: IDLE, DIV_RUN, DIV_FIX.
- Accept condition: start=1, state=IDLE, flush=0, and alu_ctrl_out is one of the six codes. Any other code, or start while busy, is ignored with no state change.
- MULT at the accept edge: {HI,LO} <= signed 64-bit op1*op2.
- MULTU at the accept edge: {HI,LO} <= unsigned 64-bit op1*op2.
- MTHI at the accept edge: HI <= op1, LO unchanged. MTLO: LO <= op1, HI unchanged.
- For MULT/MULTU/MTHI/MTLO, done=1 for the cycle after the accept edge and busy stays 0.
- DIV/DIVU with op2==0: HI/LO unchanged. done=1 and divideZero=1 for one cycle after the accept edge; busy stays 0.
- DIV/DIVU with op2!=0, at the accept edge:
  - latch dividend magnitude, divisor magnitude and sign bits; DIVU treats both operands as unsigned with signs 0;
  - clear the remainder accumulator and the iteration counter (6 bits);
  - go to DIV_RUN; busy=1 from the next cycle.
- DIV_RUN, each cycle: shift {rem, quo} left one bit, trial-subtract the divisor from rem; if the result is non-negative, commit it and set the quotient LSB. After 32 iterations go to DIV_FIX.
- DIV_FIX (one cycle):
  - LO <= quotient, negated if the signs differ;
  - HI <= remainder, negated if the dividend was negative;
  - return to IDLE; busy drops after this edge, and done=1 the following cycle.
- Divide timing: busy is high for exactly 33 cycles; HI/LO are valid 33 edges after the accept edge.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap and no overflow flag.
- flush=1 in DIV_RUN or DIV_FIX: return to IDLE at that edge. HI/LO unchanged, no done, busy=0 next cycle.
- flush and start in the same cycle: flush wins and start is ignored.
- done and divideZero are never high for more than one consecutive cycle.
- hi_out/lo_out are driven directly from the registers; no combinational path from inputs.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: hi_out/lo_out combinationally reflect the value being written by an accepted MULT/MULTU/MTHI/MTLO in the same cycle (write-through bypass). This lets an immediately following MFHI/MFLO read the new value without a stall. Divide results are not bypassed.
- Undefined: hi_out/lo_out are pure register outputs; the new value is visible only after the accept edge.

Test Plan:
1. MULT op1=0xFFFFFFFE, op2=3 -> after 1 edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once; busy stays 0.
2. MULTU op1=0xFFFFFFFE, op2=3 -> HI=0x00000002, LO=0xFFFFFFFA. Then MTHI op1=0x12345678 -> HI=0x12345678, LO unchanged.
3. DIV op1=0xFFFFFFF9 (-7), op2=2 -> busy high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF, done one cycle. Start pulsed during busy is ignored.
4. DIVU op1=100, op2=0 -> divideZero and done pulse one cycle; HI/LO unchanged; busy never rises.
5. DIV op1=0x80000000, op2=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000. DIVU op1=0xFFFFFFFF, op2=16 -> LO=0x0FFFFFFF, HI=0x0000000F.
6. Flush and reset mid-divide:
   - Start DIV op1=100, op2=7 and assert flush on the 10th busy cycle -> busy=0 next cycle, HI/LO keep their prior values, no done.
   - Restart the divide and drive reset=0 mid-run -> all outputs 0 immediately, without waiting for a clock edge.
